axi_burst_master: RTL and testbench
===================================

// Module: axi_burst_master
// PURPOSE
//  AXI4 burst traffic generator/checker; drives the slave port of axi_slave_skid.
//  On i_start it writes i_nburst INCR bursts of a known pattern, then reads them back and checks every beat.
//  It reports the error count and total cycles for throughput measurement.
//  One transaction outstanding at a time; lock/cache/prot/qos inputs of the slave tied to 0 at integration.
// PARAMETERS
//  ADDR_WIDTH    10            byte address width
//  DATA_WIDTH    32            data width; STRB_WIDTH = DATA_WIDTH/8, LSB = $clog2(DATA_WIDTH)-3
//  ID_WIDTH      2             AXI ID width
//  TXN_ID        0             constant ID driven on AWID/ARID and expected on BID/RID
// PORTS
//  ACLK                   in   1          clock, all logic on rising edge
//  ARESETn                in   1          asynchronous active-low reset
//  i_start                in   1          start pulse, sampled only in IDLE
//  i_base                 in   ADDR_WIDTH first burst byte address, word aligned
//  i_len                  in   8          AxLEN for every burst (beats-1)
//  i_nburst               in   8          number of bursts
//  o_busy, o_done         out  1,1        busy level; one-cycle completion pulse
//  o_err_cnt              out  16         saturating error count
//  o_cycles               out  32         saturating cycle count of last run
//  M_AWID/AWSIZE/AWBURST  out  ID/3/2     TXN_ID, LSB, 2'b01 (INCR), constant
//  M_AWADDR               out  ADDR_WIDTH write burst address
//  M_AWLEN                out  8          latched i_len
//  M_AWVALID/M_AWREADY    out/in 1        AW handshake
//  M_WDATA                out  DATA_WIDTH write pattern
//  M_WSTRB/M_WLAST        out  STRB/1     all ones; last beat flag
//  M_WVALID/M_WREADY      out/in 1        W handshake
//  M_BID/M_BRESP          in   ID/2       write response fields
//  M_BVALID/M_BREADY      in/out 1        B handshake
//  M_ARID/ARSIZE/ARBURST  out  ID/3/2     TXN_ID, LSB, INCR, constant
//  M_ARADDR/M_ARLEN       out  ADDR/8     read burst address, latched i_len
//  M_ARVALID/M_ARREADY    out/in 1        AR handshake
//  M_RDATA                in   DATA_WIDTH read data
//  M_RID/M_RRESP/M_RLAST  in   ID/2/1     read response fields
//  M_RVALID/M_RREADY      in/out 1        R handshake
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; all VALID/READY outputs, o_busy, o_done, counters, address/data regs 0.
//   Reset mid-burst abandons the run with no o_done.
//  FSM: IDLE -> WADDR -> WDATA -> WRESP -> (WADDR if bursts remain, else RADDR) -> RDATA -> (RADDR if remain, else DONE) -> IDLE.
//   DONE lasts 1 cycle and o_done=1 there; o_busy=1 in every state except IDLE.
//  i_start in IDLE latches i_base/i_len/i_nburst and clears o_err_cnt/o_cycles; i_start while busy is ignored.
//   i_nburst==0 goes straight to DONE.
//  Burst k address = i_base + k*(i_len+1)*STRB_WIDTH, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH).
//  Beat data = global beat index w (0.. across all bursts, restarting at 0 for the read phase), zero-extended to DATA_WIDTH.
//  VALID rises on state entry and holds with stable payload until handshake; no combinational path from READY to VALID.
//  WVALID first rises the cycle after the AW handshake; M_WLAST=1 on beat i_len; WDATA advances on each W handshake.
//  M_BREADY=1 only in WRESP; M_RREADY=1 throughout RDATA.
//  Error +1 (saturating at 16'hFFFF) for: BRESP!=0 or BID!=TXN_ID; per R beat: RDATA!=expected, RRESP!=0, RID!=TXN_ID,
//   RLAST != (beat==i_len). A single beat with several faults counts 1.
//  RDATA leaves on the cycle RLAST handshakes regardless of RLAST correctness; an early RLAST ends the burst.
//  o_cycles increments every cycle from the cycle after start acceptance through DONE inclusive, then holds until next start.
// TESTING
//  base 0x000, len 0, nburst 1 vs axi_slave_skid+mem -> 1 AW/W/B/AR/R each, RDATA 0, err 0, o_done once.
//  base 0x3C0, len 15, nburst 2, ADDR_WIDTH 10 -> AWADDR 0x3C0 then 0x000, 64 beats total, data 0..31, err 0.
//  BFM slave with random AWREADY/WREADY/ARREADY stalls -> VALID never drops early, payload stable, err 0.
//  BFM returns BRESP=2'b10 once and corrupts one RDATA beat -> o_err_cnt==2 at o_done.
//  ARESETn low during W beat 3 -> VALIDs 0 immediately, IDLE, no o_done; next run completes with err 0.
//  nburst 0 -> o_done 1 cycle after start, no bus activity; i_start during busy -> ignored, single o_done.

Source files
------------

// File: rtl/axi_burst_master.sv
// AXI4 burst traffic generator/checker: writes INCR bursts of a beat-index pattern, reads them
// back, and counts protocol/data errors and total cycles for one run.
module axi_burst_master #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned TXN_ID     = 0
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic                      i_start,
  input  logic [ADDR_WIDTH-1:0]     i_base,
  input  logic [7:0]                i_len,
  input  logic [7:0]                i_nburst,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [15:0]               o_err_cnt,
  output logic [31:0]               o_cycles,
  output logic [ID_WIDTH-1:0]       M_AWID,
  output logic [ADDR_WIDTH-1:0]     M_AWADDR,
  output logic [7:0]                M_AWLEN,
  output logic [2:0]                M_AWSIZE,
  output logic [1:0]                M_AWBURST,
  output logic                      M_AWVALID,
  input  logic                      M_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_WSTRB,
  output logic                      M_WLAST,
  output logic                      M_WVALID,
  input  logic                      M_WREADY,
  input  logic [ID_WIDTH-1:0]       M_BID,
  input  logic [1:0]                M_BRESP,
  input  logic                      M_BVALID,
  output logic                      M_BREADY,
  output logic [ID_WIDTH-1:0]       M_ARID,
  output logic [ADDR_WIDTH-1:0]     M_ARADDR,
  output logic [7:0]                M_ARLEN,
  output logic [2:0]                M_ARSIZE,
  output logic [1:0]                M_ARBURST,
  output logic                      M_ARVALID,
  input  logic                      M_ARREADY,
  input  logic [DATA_WIDTH-1:0]     M_RDATA,
  input  logic [ID_WIDTH-1:0]       M_RID,
  input  logic [1:0]                M_RRESP,
  input  logic                      M_RLAST,
  input  logic                      M_RVALID,
  output logic                      M_RREADY
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned LSB        = $clog2(DATA_WIDTH) - 3;
  localparam logic [ID_WIDTH-1:0]   TxnId   = ID_WIDTH'(TXN_ID);
  localparam logic [DATA_WIDTH-1:0] DataOne = DATA_WIDTH'(1);

  typedef enum logic [2:0] {
    StIdle, StWaddr, StWdata, StWresp, StRaddr, StRdata, StDone
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            nburst_q, nburst_d;
  logic [7:0]            burst_q, burst_d;
  logic [7:0]            beat_q, beat_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [15:0]           err_q, err_d;
  logic [31:0]           cycles_q, cycles_d;

  logic [ADDR_WIDTH-1:0] stride;
  logic                  last_burst;
  logic                  err_hit;

  // Byte distance between consecutive burst start addresses; wraps with the address.
  assign stride     = ADDR_WIDTH'((32'(len_q) + 32'd1) * STRB_WIDTH);
  assign last_burst = (burst_q == nburst_q - 8'd1);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    addr_d   = addr_q;
    len_d    = len_q;
    nburst_d = nburst_q;
    burst_d  = burst_q;
    beat_d   = beat_q;
    data_d   = data_q;
    err_d    = err_q;
    cycles_d = cycles_q;
    err_hit  = 1'b0;

    if (state_q != StIdle && cycles_q != 32'hFFFF_FFFF) begin
      cycles_d = cycles_q + 32'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          base_d   = i_base;
          addr_d   = i_base;
          len_d    = i_len;
          nburst_d = i_nburst;
          burst_d  = 8'd0;
          beat_d   = 8'd0;
          data_d   = '0;
          err_d    = 16'd0;
          cycles_d = 32'd0;
          state_d  = (i_nburst == 8'd0) ? StDone : StWaddr;
        end
      end
      StWaddr: begin
        if (M_AWREADY) state_d = StWdata;
      end
      StWdata: begin
        if (M_WREADY) begin
          data_d = data_q + DataOne;
          beat_d = beat_q + 8'd1;
          if (beat_q == len_q) begin
            beat_d  = 8'd0;
            state_d = StWresp;
          end
        end
      end
      StWresp: begin
        if (M_BVALID) begin
          err_hit = (M_BRESP != 2'b00) || (M_BID != TxnId);
          if (last_burst) begin
            // Read phase replays the same addresses and pattern from the start.
            burst_d = 8'd0;
            addr_d  = base_q;
            data_d  = '0;
            state_d = StRaddr;
          end else begin
            burst_d = burst_q + 8'd1;
            addr_d  = addr_q + stride;
            state_d = StWaddr;
          end
        end
      end
      StRaddr: begin
        if (M_ARREADY) state_d = StRdata;
      end
      StRdata: begin
        if (M_RVALID) begin
          err_hit = (M_RDATA != data_q) || (M_RRESP != 2'b00) || (M_RID != TxnId) ||
                    (M_RLAST != (beat_q == len_q));
          data_d  = data_q + DataOne;
          beat_d  = beat_q + 8'd1;
          if (M_RLAST) begin
            beat_d  = 8'd0;
            burst_d = burst_q + 8'd1;
            addr_d  = addr_q + stride;
            state_d = last_burst ? StDone : StRaddr;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (err_hit && err_q != 16'hFFFF) begin
      err_d = err_q + 16'd1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= StIdle;
      base_q   <= '0;
      addr_q   <= '0;
      len_q    <= 8'd0;
      nburst_q <= 8'd0;
      burst_q  <= 8'd0;
      beat_q   <= 8'd0;
      data_q   <= '0;
      err_q    <= 16'd0;
      cycles_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      nburst_q <= nburst_d;
      burst_q  <= burst_d;
      beat_q   <= beat_d;
      data_q   <= data_d;
      err_q    <= err_d;
      cycles_q <= cycles_d;
    end
  end

  // All handshake outputs decode the registered state, so READY never reaches VALID.
  assign o_busy    = (state_q != StIdle);
  assign o_done    = (state_q == StDone);
  assign o_err_cnt = err_q;
  assign o_cycles  = cycles_q;

  assign M_AWID    = TxnId;
  assign M_AWADDR  = addr_q;
  assign M_AWLEN   = len_q;
  assign M_AWSIZE  = 3'(LSB);
  assign M_AWBURST = 2'b01;
  assign M_AWVALID = (state_q == StWaddr);

  assign M_WDATA   = data_q;
  assign M_WSTRB   = '1;
  assign M_WLAST   = (beat_q == len_q);
  assign M_WVALID  = (state_q == StWdata);

  assign M_BREADY  = (state_q == StWresp);

  assign M_ARID    = TxnId;
  assign M_ARADDR  = addr_q;
  assign M_ARLEN   = len_q;
  assign M_ARSIZE  = 3'(LSB);
  assign M_ARBURST = 2'b01;
  assign M_ARVALID = (state_q == StRaddr);

  assign M_RREADY  = (state_q == StRdata);

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed + randomized bench: a memory-backed AXI slave BFM with optional stalls and error
// injection, checked against burst address/data/cycle expectations computed from the rules.
module tb_axi_burst_master;

  localparam int Budget = 4000;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        i_start;
  logic [9:0]  i_base;
  logic [7:0]  i_len;
  logic [7:0]  i_nburst;
  logic        o_busy, o_done;
  logic [15:0] o_err_cnt;
  logic [31:0] o_cycles;
  logic [1:0]  M_AWID, M_ARID, M_BID, M_RID;
  logic [9:0]  M_AWADDR, M_ARADDR;
  logic [7:0]  M_AWLEN, M_ARLEN;
  logic [2:0]  M_AWSIZE, M_ARSIZE;
  logic [1:0]  M_AWBURST, M_ARBURST, M_BRESP, M_RRESP;
  logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_WLAST, M_BVALID, M_BREADY;
  logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY, M_RLAST;
  logic [31:0] M_WDATA, M_RDATA;
  logic [3:0]  M_WSTRB;

  axi_burst_master dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .i_start(i_start), .i_base(i_base), .i_len(i_len),
    .i_nburst(i_nburst), .o_busy(o_busy), .o_done(o_done), .o_err_cnt(o_err_cnt),
    .o_cycles(o_cycles), .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN),
    .M_AWSIZE(M_AWSIZE), .M_AWBURST(M_AWBURST), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST), .M_WVALID(M_WVALID),
    .M_WREADY(M_WREADY), .M_BID(M_BID), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID),
    .M_BREADY(M_BREADY), .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN),
    .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RID(M_RID), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  // Written only by the main sequence, read by the BFM.
  bit stall = 1'b0;
  int bresp_err_at = -1;
  int rdata_err_at = -1;

  // Written only by the BFM, read by the main sequence.
  logic [9:0]  aw_log[$];
  logic [9:0]  ar_log[$];
  logic [31:0] w_log[$];
  logic [31:0] r_log[$];
  int done_cnt = 0, viol = 0, wlast_bad = 0, b_num = 0, r_num = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave BFM: each negedge applies the handshakes that completed at the previous posedge,
  // drives fresh READY/response values, then notes which handshakes the next posedge takes.
  initial begin
    logic [31:0] mem [256];
    logic [7:0]  wr_idx, rd_idx, w_beat, r_beat, rd_len, idx;
    bit          aw_hs, w_hs, b_hs, ar_hs, r_hs, b_pend, r_active;
    bit          p_awv, p_wv, p_arv, w_last_c;
    logic [9:0]  aw_addr_c, ar_addr_c;
    logic [7:0]  aw_len_c, ar_len_c;
    logic [31:0] w_data_c, r_data_c;
    logic [63:0] w_pay;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    {aw_hs, w_hs, b_hs, ar_hs, r_hs, b_pend, r_active, p_awv, p_wv, p_arv} = '0;
    {wr_idx, rd_idx, w_beat, r_beat, rd_len} = '0;
    M_AWREADY = 0; M_WREADY = 0; M_ARREADY = 0; M_BVALID = 0; M_RVALID = 0;
    M_BID = 0; M_BRESP = 0; M_RID = 0; M_RRESP = 0; M_RLAST = 0; M_RDATA = 0;
    forever begin
      @(negedge ACLK);
      if (o_done) done_cnt++;
      if (!ARESETn) begin
        {aw_hs, w_hs, b_hs, ar_hs, r_hs, b_pend, r_active, p_awv, p_wv, p_arv} = '0;
        M_BVALID = 0; M_RVALID = 0;
        continue;
      end
      // VALID must hold with a stable payload until its handshake.
      if (p_awv && !aw_hs && (!M_AWVALID || M_AWADDR !== aw_addr_c || M_AWLEN !== aw_len_c))
        viol++;
      if (p_wv && !w_hs && (!M_WVALID || {M_WDATA, 31'd0, M_WLAST} !== w_pay)) viol++;
      if (p_arv && !ar_hs && (!M_ARVALID || M_ARADDR !== ar_addr_c || M_ARLEN !== ar_len_c))
        viol++;
      if (aw_hs) begin
        wr_idx = aw_addr_c[9:2]; w_beat = 0; aw_log.push_back(aw_addr_c);
      end
      if (w_hs) begin
        idx = wr_idx + w_beat;
        mem[idx] = w_data_c;
        w_log.push_back(w_data_c);
        if (w_last_c != (w_beat == aw_len_c)) wlast_bad++;
        if (w_last_c) b_pend = 1;
        w_beat++;
      end
      if (b_hs) begin b_pend = 0; b_num++; end
      if (ar_hs) begin
        rd_idx = ar_addr_c[9:2]; rd_len = ar_len_c; r_beat = 0; r_active = 1;
        ar_log.push_back(ar_addr_c);
      end
      if (r_hs) begin
        r_log.push_back(r_data_c);
        if (r_beat == rd_len) r_active = 0;
        r_beat++; r_num++;
      end
      M_AWREADY = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      M_WREADY  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      M_ARREADY = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      M_BVALID  = b_pend;
      M_BRESP   = (b_num == bresp_err_at) ? 2'b10 : 2'b00;
      idx       = rd_idx + r_beat;
      r_data_c  = mem[idx];
      M_RVALID  = r_active && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
      M_RDATA   = (r_num == rdata_err_at) ? (r_data_c ^ 32'h100) : r_data_c;
      M_RLAST   = (r_beat == rd_len);
      aw_hs = M_AWVALID && M_AWREADY; aw_addr_c = M_AWADDR; aw_len_c = M_AWLEN; p_awv = M_AWVALID;
      w_hs  = M_WVALID && M_WREADY;   w_data_c = M_WDATA;   w_last_c = M_WLAST; p_wv = M_WVALID;
      w_pay = {M_WDATA, 31'd0, M_WLAST};
      ar_hs = M_ARVALID && M_ARREADY; ar_addr_c = M_ARADDR; ar_len_c = M_ARLEN; p_arv = M_ARVALID;
      b_hs  = M_BVALID && M_BREADY;
      r_hs  = M_RVALID && M_RREADY;
    end
  end

  // One run, checked against the burst rules: addresses base + k*(len+1)*4 mod 1024, data equal
  // to the beat index per phase, and (without stalls) 2*len+5 cycles per burst plus DONE.
  task automatic run(input logic [9:0] base, input logic [7:0] len, input logic [7:0] nb,
                     input int exp_err, input bit poke);
    int aw0, w0, ar0, r0, d0, v0, wl0, cyc, nbeats;
    logic [9:0] exp_addr;
    aw0 = aw_log.size(); w0 = w_log.size(); ar0 = ar_log.size(); r0 = r_log.size();
    d0 = done_cnt; v0 = viol; wl0 = wlast_bad;
    nbeats = int'(nb) * (int'(len) + 1);
    @(negedge ACLK);
    i_base = base; i_len = len; i_nburst = nb; i_start = 1;
    @(negedge ACLK);
    i_start = 0;
    cyc = 1;
    while (!o_done && cyc < Budget) begin
      if (poke && cyc == 3) begin
        i_start = 1; i_nburst = 8'd0; i_base = ~base; i_len = 8'd3;
      end else begin
        i_start = 0;
      end
      @(negedge ACLK);
      cyc++;
    end
    i_start = 0;
    check("done_seen", o_done, 1);
    check("err_cnt_at_done", o_err_cnt, 64'(exp_err));
    @(negedge ACLK);
    @(negedge ACLK);
    check("cycles_measured", o_cycles, 64'(cyc));
    if (!stall) check("cycles_model", o_cycles, 64'(int'(nb) * (2 * int'(len) + 5) + 1));
    check("done_once", done_cnt - d0, 1);
    check("busy_after", o_busy, 0);
    check("aw_count", aw_log.size() - aw0, 64'(nb));
    check("ar_count", ar_log.size() - ar0, 64'(nb));
    for (int k = 0; k < int'(nb) && aw0 + k < aw_log.size(); k++) begin
      exp_addr = 10'(int'(base) + k * (int'(len) + 1) * 4);
      check("aw_addr", aw_log[aw0 + k], exp_addr);
      if (ar0 + k < ar_log.size()) check("ar_addr", ar_log[ar0 + k], exp_addr);
    end
    check("w_beats", w_log.size() - w0, 64'(nbeats));
    check("r_beats", r_log.size() - r0, 64'(nbeats));
    for (int i = 0; i < nbeats && w0 + i < w_log.size(); i++) check("w_data", w_log[w0 + i], i);
    for (int i = 0; i < nbeats && r0 + i < r_log.size(); i++) check("r_mem", r_log[r0 + i], i);
    check("valid_stable", viol - v0, 0);
    check("wlast_pos", wlast_bad - wl0, 0);
  endtask

  initial begin
    int d0, w0, n;
    ARESETn = 0; i_start = 0; i_base = 0; i_len = 0; i_nburst = 0;
    repeat (3) @(negedge ACLK);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err_cnt, 0);
    check("rst_cycles", o_cycles, 0);
    check("rst_valids", {M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY}, 0);
    check("rst_addr", M_AWADDR, 0);
    check("const_size_burst", {M_AWSIZE, M_AWBURST, M_ARSIZE, M_ARBURST}, 10'b010_01_010_01);
    check("const_strb_id", {M_WSTRB, M_AWID, M_ARID}, 8'hF0);
    ARESETn = 1;

    // Minimal single-beat run, then a run whose second burst wraps to address 0.
    run(10'h000, 8'd0, 8'd1, 0, 1'b0);
    run(10'h3C0, 8'd15, 8'd2, 0, 1'b0);

    // Zero bursts: straight to DONE with no bus traffic.
    run(10'h040, 8'd0, 8'd0, 0, 1'b0);

    // Randomized shapes with READY stalls; the first also pokes i_start while busy.
    stall = 1'b1;
    for (int t = 0; t < 3; t++) begin
      run(10'($urandom_range(0, 255) << 2), 8'($urandom_range(0, 7)),
          8'($urandom_range(1, 4)), 0, (t == 0));
    end

    // One bad write response and one corrupted read beat.
    bresp_err_at = b_num + 1;
    rdata_err_at = r_num + 5;
    run(10'h100, 8'd3, 8'd3, 2, 1'b0);
    bresp_err_at = -1;
    rdata_err_at = -1;

    // Reset in the middle of W beat 3.
    stall = 1'b0;
    d0 = done_cnt; w0 = w_log.size();
    @(negedge ACLK);
    i_base = 10'h080; i_len = 8'd7; i_nburst = 8'd2; i_start = 1;
    @(negedge ACLK);
    i_start = 0;
    n = 0;
    while (w_log.size() - w0 < 3 && n < Budget) begin
      @(negedge ACLK);
      n++;
    end
    check("mid_reset_reached", w_log.size() - w0, 3);
    #2 ARESETn = 0;
    #1;
    check("mid_reset_valids", {M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY}, 0);
    check("mid_reset_busy", o_busy, 0);
    repeat (4) @(negedge ACLK);
    ARESETn = 1;
    repeat (2) @(negedge ACLK);
    check("mid_reset_no_done", done_cnt - d0, 0);
    run(10'h080, 8'd7, 8'd2, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
